// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus IF/ID pipeline register with one-delay-slot redirects.
//   clk_in          : clock, all state updates on its rising edge
//   reset_n_in      : asynchronous active-low reset
//   stall_in        : hold PC and IF/ID
//   clear_in        : load a bubble into IF/ID (wins over stall for IF/ID only)
//   npc_sel_in      : next-PC select, 00 seq / 01 branch / 10 jump / 11 jr
//   branch_taken_in : branch compare result for the ID-stage instruction
//   jr_target_in    : forwarded rs value for jr
//   imem_addr_out   : instruction memory address (current PC)
//   imem_data_in    : combinational instruction memory read data
//   id_instr_out    : IF/ID instruction
//   id_pc_out       : PC of id_instr_out
//   id_pc8_out      : id_pc_out + 8, link address for jal
//   id_valid_out    : IF/ID holds a real fetched instruction
//   fetch_err_out   : IF/ID holds a misaligned-fetch bubble
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        stall_in,
    input  logic        clear_in,
    input  logic [1:0]  npc_sel_in,
    input  logic        branch_taken_in,
    input  logic [31:0] jr_target_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic [31:0] id_instr_out,
    output logic [31:0] id_pc_out,
    output logic [31:0] id_pc8_out,
    output logic        id_valid_out,
    output logic        fetch_err_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        id_err_q, id_err_d;
    logic [31:0] seq_pc, br_pc, j_pc, npc;
    logic        misaligned;

    always_comb begin
        seq_pc     = pc_q + 32'd4;
        // Branch/jump targets are relative to the instruction in ID, whose delay slot is the current PC.
        br_pc      = id_pc_q + 32'd4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
        j_pc       = {id_pc_q[31:28], id_instr_q[25:0], 2'b00};
        npc        = npc_sel_in == 2'b00 ? seq_pc :
                     npc_sel_in == 2'b01 ? (branch_taken_in ? br_pc : seq_pc) :
                     npc_sel_in == 2'b10 ? j_pc : jr_target_in;
        pc_d       = stall_in ? pc_q : npc;
        misaligned = pc_q[1:0] != 2'b00;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        id_err_d   = id_err_q;
        if (clear_in) begin
            id_instr_d = NOP_WORD;
            id_pc_d    = pc_q;
            id_valid_d = 1'b0;
            id_err_d   = 1'b0;
        end else if (!stall_in) begin
            id_instr_d = misaligned ? NOP_WORD : imem_data_in;
            id_pc_d    = pc_q;
            id_valid_d = !misaligned;
            id_err_d   = misaligned;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NOP_WORD;
            id_pc_q    <= RESET_PC;
            id_valid_q <= 1'b0;
            id_err_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            id_err_q   <= id_err_d;
        end
    end

    assign imem_addr_out = pc_q;
    assign id_instr_out  = id_instr_q;
    assign id_pc_out     = id_pc_q;
    assign id_pc8_out    = id_pc_q + 32'd8;
    assign id_valid_out  = id_valid_q;
    assign fetch_err_out = id_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a behavioural fetch model and literal checkpoints.
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [1:0]  npc_sel_in = 2'b00;
    logic        branch_taken_in = 1'b0;
    logic [31:0] jr_target_in = 32'h0;
    logic [31:0] imem_addr_out, imem_data_in;
    logic [31:0] id_instr_out, id_pc_out, id_pc8_out;
    logic        id_valid_out, fetch_err_out;

    int total = 0;
    int passed = 0;

    fetch_unit dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .stall_in(stall_in), .clear_in(clear_in),
        .npc_sel_in(npc_sel_in), .branch_taken_in(branch_taken_in), .jr_target_in(jr_target_in),
        .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
        .id_instr_out(id_instr_out), .id_pc_out(id_pc_out), .id_pc8_out(id_pc8_out),
        .id_valid_out(id_valid_out), .fetch_err_out(fetch_err_out)
    );

    always #5 clk_in = ~clk_in;

    // Instruction memory: a beq and a j placed in the program, everything else addr ^ A5A5_0000.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_3004: return 32'h1000_FFFE;
            32'h0000_3010: return 32'h0800_0C40;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign imem_data_in = mem_rd(imem_addr_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: PC plus the four IF/ID fields.
    logic [31:0] m_pc, m_instr, m_idpc;
    logic        m_valid, m_err;

    function automatic logic [31:0] model_next();
        int off;
        off = int'($signed(m_instr[15:0])) * 4;
        case (npc_sel_in)
            2'd0: return m_pc + 32'd4;
            2'd1: return branch_taken_in ? m_idpc + 32'd4 + 32'(off) : m_pc + 32'd4;
            2'd2: return (m_idpc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            default: return jr_target_in;
        endcase
    endfunction

    always @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            m_pc <= 32'h3000; m_instr <= 32'h0; m_idpc <= 32'h3000; m_valid <= 1'b0; m_err <= 1'b0;
        end else begin
            if (!stall_in) m_pc <= model_next();
            if (clear_in) begin
                m_instr <= 32'h0; m_idpc <= m_pc; m_valid <= 1'b0; m_err <= 1'b0;
            end else if (!stall_in) begin
                m_idpc  <= m_pc;
                m_valid <= (m_pc % 4) == 0;
                m_err   <= (m_pc % 4) != 0;
                m_instr <= (m_pc % 4) == 0 ? mem_rd(m_pc) : 32'h0;
            end
        end
    end

    always @(negedge clk_in) begin
        chk("imem_addr", imem_addr_out, m_pc);
        chk("id_instr", id_instr_out, m_instr);
        chk("id_pc", id_pc_out, m_idpc);
        chk("id_pc8", id_pc8_out, m_idpc + 32'd8);
        chk("id_valid", {31'b0, id_valid_out}, {31'b0, m_valid});
        chk("fetch_err", {31'b0, fetch_err_out}, {31'b0, m_err});
    end

    // Drive one cycle's inputs, then return at negedge+1 after the edge that used them.
    task automatic cyc(input logic [1:0] sel, input logic tk, input logic [31:0] jr,
                       input logic st, input logic cl);
        npc_sel_in = sel; branch_taken_in = tk; jr_target_in = jr; stall_in = st; clear_in = cl;
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_addr", imem_addr_out, 32'h3000);
        chk("rst_pc8", id_pc8_out, 32'h3008);
        chk("rst_valid", {31'b0, id_valid_out}, 32'h0);
        reset_n_in = 1'b1;
        cyc(2'd0, 0, 0, 0, 0);
        chk("seq1_pc", id_pc_out, 32'h3000);
        chk("seq1_valid", {31'b0, id_valid_out}, 32'h1);
        cyc(2'd0, 0, 0, 0, 0);
        chk("seq2_instr", id_instr_out, 32'h1000_FFFE);
        cyc(2'd1, 1, 0, 0, 0);
        chk("slot_pc", id_pc_out, 32'h3008);
        chk("slot_instr", id_instr_out, 32'hA5A5_3008);
        chk("br_target", imem_addr_out, 32'h3000);
        repeat (5) cyc(2'd0, 0, 0, 0, 0);
        chk("j_in_id", id_pc_out, 32'h3010);
        chk("j_pc8", id_pc8_out, 32'h3018);
        cyc(2'd2, 0, 0, 0, 0);
        chk("j_target", imem_addr_out, 32'h3100);
        cyc(2'd3, 0, 32'h3018, 0, 0);
        chk("jr_target", imem_addr_out, 32'h3018);
        cyc(2'd2, 0, 0, 1, 0);
        cyc(2'd2, 0, 0, 1, 0);
        chk("stall_addr", imem_addr_out, 32'h3018);
        chk("stall_idpc", id_pc_out, 32'h3100);
        cyc(2'd0, 0, 0, 1, 1);
        chk("sc_valid", {31'b0, id_valid_out}, 32'h0);
        chk("sc_instr", id_instr_out, 32'h0);
        chk("sc_addr", imem_addr_out, 32'h3018);
        cyc(2'd0, 0, 0, 0, 1);
        chk("clr_addr", imem_addr_out, 32'h301C);
        cyc(2'd1, 0, 0, 0, 0);
        chk("nt_addr", imem_addr_out, 32'h3020);
        cyc(2'd3, 0, 32'h3002, 0, 0);
        cyc(2'd0, 0, 0, 0, 0);
        chk("mis_err", {31'b0, fetch_err_out}, 32'h1);
        chk("mis_valid", {31'b0, id_valid_out}, 32'h0);
        chk("mis_addr", imem_addr_out, 32'h3006);
        cyc(2'd3, 0, 32'hFFFF_FFFC, 0, 0);
        cyc(2'd0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr_out, 32'h0);
        chk("wrap_pc8", id_pc8_out, 32'h4);
        chk("wrap_instr", id_instr_out, 32'h5A5A_FFFC);
        cyc(2'd0, 0, 0, 0, 0);
        stall_in = 1'b1;
        npc_sel_in = 2'd2;
        @(posedge clk_in);
        #2 reset_n_in = 1'b0;
        #1;
        chk("arst_addr", imem_addr_out, 32'h3000);
        chk("arst_idpc", id_pc_out, 32'h3000);
        chk("arst_valid", {31'b0, id_valid_out}, 32'h0);
        @(negedge clk_in);
        #1 reset_n_in = 1'b1;
        cyc(2'd0, 0, 0, 0, 0);
        chk("post_rst", id_pc_out, 32'h3000);
        cyc(2'd0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
